qrd_skew_feeder: RTL and testbench
==================================

Name: qrd_skew_feeder

Overview:
- Parametrised front end for the systolic complex QR decomposition core.
- Accepts an NxN complex matrix H column by column over a valid/ready stream and buffers it.
- Optionally appends the NxN identity, giving the augmented matrix [H | I]. This lets the core produce Q^H alongside R.
- Emits the per-row skewed, zero-padded, flagged beat sequence the core expects, advancing only while the core signals ready.

Parameters:
N, 4, matrix dimension (rows = core row inputs), N >= 2
W, 14, signed two's-complement width of each real/imag component
FRAC, 10, fraction bits; identity diagonal value = 1 << FRAC (1024 at default)
TAIL, 5, extra all-zero drain beats appended after the skewed data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
col_in_r  in  N*W  real parts of one H column; row j in bits [j*W +: W]
col_in_i  in  N*W  imaginary parts, same packing
col_in_valid  in  1  upstream column valid
col_in_ready  out  1  feeder can accept a column
aug_en  in  1  append identity when 1; sampled with the first column of a frame
core_ready  in  1  core in_ready; a beat is consumed on each rising edge with core_ready=1
row_out_r  out  N*W  real part of the current beat for row k, bits [k*W +: W]
row_out_i  out  N*W  imaginary part of the current beat
row_out_f  out  N-1  vectoring-start flag for rows 0..N-2
row_out_valid  out  1  a frame beat is being presented
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after the last beat is consumed

Behaviour:
- Reset (asynchronous, any state): state=IDLE, column counter=0, beat counter=0, matrix buffer cleared.
- Output values in reset: row_out_r/i/f=0, row_out_valid=0, frame_done=0, col_in_ready=1, busy=0.
- States: IDLE, LOAD, FEED.
- Column handshake: a column is accepted on a rising edge with col_in_valid and col_in_ready both 1. col_in_ready = (state != FEED).
- IDLE: on acceptance, store column 0, latch aug_en into aug_q, set col_cnt=1, go to LOAD.
- LOAD: each acceptance stores column col_cnt into M[j][col_cnt]. On acceptance of column N-1, go to FEED with beat counter l=0. Beat 0 is registered onto the outputs on that same edge.
- Column count C = aug_q ? 2N : N. Total beats L = C + N - 1 + TAIL. At defaults with aug_en=1, L = 16.
- Augmented entries: for c >= N, M[k][c] is (1<<FRAC) real when c-N == k, otherwise 0. Imaginary part is always 0. These entries are generated, not stored.
- Beat l, row k data: M[k][l-k] when k <= l < k+C, otherwise 0 (real and imaginary).
- Beat l flags: row_out_f[k] = 1 exactly when l == 2k.
- FEED: row_out_valid=1 and the outputs hold beat l.
  - Rising edge with core_ready=1: if l < L-1, load beat l+1 and set l=l+1. If l == L-1, clear all outputs to 0, go to IDLE, and pulse frame_done for the following cycle.
  - Rising edge with core_ready=0: outputs and l hold unchanged; stalls are unbounded.
- Back-to-back frames: frame_done and col_in_ready=1 coexist. A column can be accepted in the first IDLE cycle after FEED. The minimum frame period is N + L cycles.
- col_in_valid during FEED is ignored; the upstream holds its data.
- aug_en changes after the first column of a frame have no effect on that frame.
- No arithmetic beyond selection: data passes bit-exact; 1<<FRAC must fit in W-1 bits (FRAC <= W-2).

Test Plan:
- Default params, aug_en=1, core_ready=1, H[j][k] = (10j+k) + (-(10j+k))j:
  - row_out_valid rises on the edge accepting column 3.
  - Row 0 beats 0..3 = 0,1,2,3 (imag 0,-1,-2,-3); beat 4 = 1024+0j; beats 5..7 = 0.
  - Row 3 real: beats 0..2 = 0; beats 3..6 = 30..33; beat 10 = 1024.
  - row_out_f = 001, 010, 100 at beats 0, 2, 4 only.
  - frame_done pulses after beat 15.
- Same frame with aug_en=0: L=12; every row's beats at index >= k+4 are 0; frame_done after beat 11.
- core_ready toggling 1,0,0,1 during FEED: outputs frozen during the 0 cycles; no beat skipped or duplicated; sequence identical to the first scenario.
- col_in_valid held high through FEED with changing data: col_in_ready=0; buffer unchanged. The next frame's column 0 is accepted on the first IDLE cycle.
- rst_n pulsed low at beat 7: all outputs 0 and col_in_ready=1 immediately (asynchronous). After release, a new 4-column frame feeds correctly from beat 0.
- N=8, W=16, FRAC=12, TAIL=0, aug_en=1: L=23; row 7 flag never exists; row 6 flag at beat 12; diagonal = 4096.

Source files
------------

// File: rtl/qrd_skew_feeder.sv
// qrd_skew_feeder: buffers an NxN complex matrix column by column, optionally
// augments it with the identity, and streams the per-row skewed, zero-padded,
// flagged beat sequence consumed by the systolic QR core.
module qrd_skew_feeder #(
    parameter int N    = 4,
    parameter int W    = 14,
    parameter int FRAC = 10,
    parameter int TAIL = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   col_in_r,
    input  logic [N*W-1:0]   col_in_i,
    input  logic             col_in_valid,
    output logic             col_in_ready,
    input  logic             aug_en,
    input  logic             core_ready,
    output logic [N*W-1:0]   row_out_r,
    output logic [N*W-1:0]   row_out_i,
    output logic [N-2:0]     row_out_f,
    output logic             row_out_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(N);
    localparam int BW = $clog2(3*N + TAIL);
    // Index of the final beat, with and without the identity block.
    localparam int unsigned LAST_AUG = 3*N - 2 + TAIL;
    localparam int unsigned LAST_RAW = 2*N - 2 + TAIL;
    localparam int          DIAG_I   = 1 << FRAC;
    localparam logic [W-1:0] DIAG    = DIAG_I[W-1:0];

    typedef enum logic [1:0] {IDLE, LOAD, FEED} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_cnt_q, col_cnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              aug_q, aug_d;
    logic              done_q, done_d;
    logic [N*W-1:0]    out_r_q, out_r_d;
    logic [N*W-1:0]    out_i_q, out_i_d;
    logic [N-2:0]      out_f_q, out_f_d;

    // Buffer: one packed vector per row, column c at bits [c*W +: W].
    logic [N*W-1:0]    m_r_q [N];
    logic [N*W-1:0]    m_i_q [N];

    logic              accept;
    logic              wr_en;
    int unsigned       wr_col;
    int unsigned       gen_idx;
    int unsigned       last_beat;
    logic [N*W-1:0]    gen_r;
    logic [N*W-1:0]    gen_i;
    logic [N-2:0]      gen_f;

    assign accept        = col_in_valid && (state_q != FEED);
    assign col_in_ready  = (state_q != FEED);
    assign busy          = (state_q != IDLE);
    assign row_out_valid = (state_q == FEED);
    assign row_out_r     = out_r_q;
    assign row_out_i     = out_i_q;
    assign row_out_f     = out_f_q;
    assign frame_done    = done_q;

    // Beat generator: builds the beat that will be registered next (beat 0
    // while loading, beat_q+1 while feeding); identity entries are synthesised.
    always_comb begin
        int unsigned c;
        int unsigned ccount;
        gen_r   = '0;
        gen_i   = '0;
        gen_f   = '0;
        c       = 0;
        ccount  = aug_q ? 2*N : N;
        gen_idx = (state_q == FEED) ? 32'(beat_q) + 32'd1 : 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gen_idx >= k && gen_idx < k + ccount) begin
                c = gen_idx - k;
                if (c < N) begin
                    gen_r[k*W +: W] = m_r_q[k][c*W +: W];
                    gen_i[k*W +: W] = m_i_q[k][c*W +: W];
                end else if (c == N + k) begin
                    gen_r[k*W +: W] = DIAG;
                end
            end
        end
        for (int unsigned k = 0; k < N - 1; k++) begin
            gen_f[k] = (gen_idx == 2*k);
        end
    end

    // Next-state and output-register logic for IDLE/LOAD/FEED.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        beat_d    = beat_q;
        aug_d     = aug_q;
        done_d    = 1'b0;
        out_r_d   = out_r_q;
        out_i_d   = out_i_q;
        out_f_d   = out_f_q;
        wr_en     = 1'b0;
        wr_col    = (state_q == IDLE) ? 32'd0 : 32'(col_cnt_q);
        last_beat = aug_q ? LAST_AUG : LAST_RAW;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_en     = 1'b1;
                    aug_d     = aug_en;
                    col_cnt_d = CW'(1);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (32'(col_cnt_q) == N - 1) begin
                        // Column N-1 lands this edge, but beat 0 only reads column 0.
                        state_d   = FEED;
                        col_cnt_d = '0;
                        beat_d    = '0;
                        out_r_d   = gen_r;
                        out_i_d   = gen_i;
                        out_f_d   = gen_f;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            FEED: begin
                if (core_ready) begin
                    if (32'(beat_q) == last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        beat_d  = '0;
                        out_r_d = '0;
                        out_i_d = '0;
                        out_f_d = '0;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        out_r_d = gen_r;
                        out_i_d = gen_i;
                        out_f_d = gen_f;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            beat_q    <= '0;
            aug_q     <= 1'b0;
            done_q    <= 1'b0;
            out_r_q   <= '0;
            out_i_q   <= '0;
            out_f_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            beat_q    <= beat_d;
            aug_q     <= aug_d;
            done_q    <= done_d;
            out_r_q   <= out_r_d;
            out_i_q   <= out_i_d;
            out_f_q   <= out_f_d;
        end
    end

    // Matrix buffer: the accepted column is scattered across the row vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N; j++) begin
                m_r_q[j] <= '0;
                m_i_q[j] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned j = 0; j < N; j++) begin
                m_r_q[j][wr_col*W +: W] <= col_in_r[j*W +: W];
                m_i_q[j][wr_col*W +: W] <= col_in_i[j*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_qrd_skew_feeder.sv
// Directed bench for qrd_skew_feeder: default 4x4 instance plus an 8x8 instance.
module tb_qrd_skew_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [55:0]  col_in_r, col_in_i;
    logic         col_in_valid, col_in_ready, aug_en, core_ready;
    logic [55:0]  row_out_r, row_out_i;
    logic [2:0]   row_out_f;
    logic         row_out_valid, busy, frame_done;

    logic [127:0] c8_r, c8_i, o8_r, o8_i;
    logic         c8_valid, c8_ready, aug8, cr8, o8_valid, busy8, done8;
    logic [6:0]   o8_f;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qrd_skew_feeder u_dut (
        .clk(clk), .rst_n(rst_n), .col_in_r(col_in_r), .col_in_i(col_in_i),
        .col_in_valid(col_in_valid), .col_in_ready(col_in_ready), .aug_en(aug_en),
        .core_ready(core_ready), .row_out_r(row_out_r), .row_out_i(row_out_i),
        .row_out_f(row_out_f), .row_out_valid(row_out_valid), .busy(busy),
        .frame_done(frame_done)
    );

    qrd_skew_feeder #(.N(8), .W(16), .FRAC(12), .TAIL(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .col_in_r(c8_r), .col_in_i(c8_i),
        .col_in_valid(c8_valid), .col_in_ready(c8_ready), .aug_en(aug8),
        .core_ready(cr8), .row_out_r(o8_r), .row_out_i(o8_i),
        .row_out_f(o8_f), .row_out_valid(o8_valid), .busy(busy8),
        .frame_done(done8)
    );

    // Expected entry of row k at beat l, with H[j][c] = base+10j+c (imag negated).
    function automatic int el(int n, int k, int l, bit aug, int base, int diag, bit im);
        int cc = aug ? 2*n : n;
        int c;
        if (l < k || l >= k + cc) return 0;
        c = l - k;
        if (c < n) return im ? -(base + 10*k + c) : (base + 10*k + c);
        if (!im && c == n + k) return diag;
        return 0;
    endfunction

    function automatic logic [55:0] exp4(int l, bit aug, int base, bit im);
        logic [55:0] v = '0;
        for (int k = 0; k < 4; k++) v[k*14 +: 14] = 14'(el(4, k, l, aug, base, 1024, im));
        return v;
    endfunction

    function automatic logic [2:0] expf4(int l);
        logic [2:0] f = '0;
        for (int k = 0; k < 3; k++) f[k] = (l == 2*k);
        return f;
    endfunction

    function automatic logic [127:0] exp8(int l, bit im);
        logic [127:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(el(8, k, l, 1'b1, 0, 4096, im));
        return v;
    endfunction

    function automatic logic [6:0] expf8(int l);
        logic [6:0] f = '0;
        for (int k = 0; k < 7; k++) f[k] = (l == 2*k);
        return f;
    endfunction

    // Present column c of the base-offset matrix and wait one cycle.
    task automatic drive_col4(input int c, input int base, input bit aug);
        for (int j = 0; j < 4; j++) begin
            col_in_r[j*14 +: 14] = 14'(base + 10*j + c);
            col_in_i[j*14 +: 14] = 14'(-(base + 10*j + c));
        end
        col_in_valid = 1'b1;
        aug_en = aug;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; col_in_r = '0; col_in_i = '0; col_in_valid = 1'b0;
        aug_en = 1'b0; core_ready = 1'b1;
        c8_r = '0; c8_i = '0; c8_valid = 1'b0; aug8 = 1'b0; cr8 = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (row_out_r !== '0) begin failures++; $display("FAIL reset_r got=%h want=0", row_out_r); end
        checks++; if (row_out_i !== '0) begin failures++; $display("FAIL reset_i got=%h want=0", row_out_i); end
        checks++; if (row_out_f !== 3'b000) begin failures++; $display("FAIL reset_f got=%b want=000", row_out_f); end
        checks++; if (row_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", row_out_valid); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", frame_done); end
        checks++; if (col_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", col_in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || row_out_valid !== 1'b0 || o8_valid !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle busy=%b valid=%b valid8=%b want=0,0,0", busy, row_out_valid, o8_valid); end
    endtask

    task automatic test_aug_frame;
        core_ready = 1'b1;
        for (int c = 0; c < 3; c++) drive_col4(c, 0, c == 0);
        checks++; if (row_out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL aug_load_state valid=%b busy=%b want=0,1", row_out_valid, busy); end
        drive_col4(3, 0, 1'b0);
        col_in_valid = 1'b0;
        checks++; if (row_out_valid !== 1'b1) begin failures++; $display("FAIL aug_valid_rise got=%b want=1", row_out_valid); end
        for (int l = 0; l < 16; l++) begin
            checks++; if (row_out_r !== exp4(l, 1, 0, 0)) begin failures++; $display("FAIL aug_r beat=%0d got=%h want=%h", l, row_out_r, exp4(l, 1, 0, 0)); end
            checks++; if (row_out_i !== exp4(l, 1, 0, 1)) begin failures++; $display("FAIL aug_i beat=%0d got=%h want=%h", l, row_out_i, exp4(l, 1, 0, 1)); end
            checks++; if (row_out_f !== expf4(l)) begin failures++; $display("FAIL aug_f beat=%0d got=%b want=%b", l, row_out_f, expf4(l)); end
            checks++; if (frame_done !== 1'b0 || row_out_valid !== 1'b1) begin failures++; $display("FAIL aug_mid beat=%0d done=%b valid=%b want=0,1", l, frame_done, row_out_valid); end
            if (l == 4) begin
                checks++; if (row_out_r[13:0] !== 14'd1024) begin failures++; $display("FAIL aug_row0_diag got=%0d want=1024", row_out_r[13:0]); end
            end
            if (l == 10) begin
                checks++; if (row_out_r[55:42] !== 14'd1024) begin failures++; $display("FAIL aug_row3_diag got=%0d want=1024", row_out_r[55:42]); end
            end
            @(negedge clk);
        end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL aug_done got=%b want=1", frame_done); end
        checks++; if (row_out_valid !== 1'b0 || row_out_r !== '0 || col_in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL aug_end valid=%b r=%h ready=%b busy=%b want=0,0,1,0", row_out_valid, row_out_r, col_in_ready, busy); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL aug_done_pulse got=%b want=0", frame_done); end
    endtask

    task automatic test_noaug;
        for (int c = 0; c < 4; c++) drive_col4(c, 0, c != 0);
        col_in_valid = 1'b0;
        for (int l = 0; l < 12; l++) begin
            checks++; if (row_out_r !== exp4(l, 0, 0, 0)) begin failures++; $display("FAIL noaug_r beat=%0d got=%h want=%h", l, row_out_r, exp4(l, 0, 0, 0)); end
            checks++; if (row_out_i !== exp4(l, 0, 0, 1)) begin failures++; $display("FAIL noaug_i beat=%0d got=%h want=%h", l, row_out_i, exp4(l, 0, 0, 1)); end
            if (l == 3) begin
                checks++; if (row_out_r[55:42] !== 14'd30) begin failures++; $display("FAIL noaug_row3_first got=%0d want=30", row_out_r[55:42]); end
            end
            if (l >= 7) begin
                checks++; if (row_out_r !== '0 || row_out_valid !== 1'b1) begin failures++; $display("FAIL noaug_zero_tail beat=%0d r=%h valid=%b want=0,1", l, row_out_r, row_out_valid); end
            end
            @(negedge clk);
        end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL noaug_done got=%b want=1", frame_done); end
    endtask

    task automatic test_stall;
        logic [3:0] pat;
        int l;
        int cyc;
        pat = 4'b1001;
        for (int c = 0; c < 4; c++) drive_col4(c, 0, c == 0);
        col_in_valid = 1'b0;
        l = 0;
        cyc = 0;
        while (l < 16 && cyc < 100) begin
            checks++; if (row_out_r !== exp4(l, 1, 0, 0) || row_out_i !== exp4(l, 1, 0, 1) || row_out_f !== expf4(l)) begin
                failures++; $display("FAIL stall_beat beat=%0d cyc=%0d got=%h want=%h", l, cyc, row_out_r, exp4(l, 1, 0, 0)); end
            core_ready = pat[cyc % 4];
            @(negedge clk);
            if (core_ready) l++;
            cyc++;
        end
        core_ready = 1'b1;
        checks++; if (l != 16) begin failures++; $display("FAIL stall_timeout beats=%0d want=16", l); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b want=1", frame_done); end
    endtask

    task automatic test_feed_ignore;
        for (int c = 0; c < 4; c++) drive_col4(c, 0, 1'b0);
        for (int l = 0; l < 12; l++) begin
            for (int j = 0; j < 4; j++) begin
                col_in_r[j*14 +: 14] = 14'(l == 11 ? 50 + 10*j : 100 + l + j);
                col_in_i[j*14 +: 14] = 14'(l == 11 ? -(50 + 10*j) : -(100 + l + j));
            end
            col_in_valid = 1'b1;
            aug_en = 1'b1;
            checks++; if (col_in_ready !== 1'b0) begin failures++; $display("FAIL ign_ready beat=%0d got=%b want=0", l, col_in_ready); end
            checks++; if (row_out_r !== exp4(l, 0, 0, 0) || row_out_i !== exp4(l, 0, 0, 1)) begin
                failures++; $display("FAIL ign_data beat=%0d got=%h want=%h", l, row_out_r, exp4(l, 0, 0, 0)); end
            @(negedge clk);
        end
        checks++; if (frame_done !== 1'b1 || col_in_ready !== 1'b1) begin
            failures++; $display("FAIL ign_b2b done=%b ready=%b want=1,1", frame_done, col_in_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || frame_done !== 1'b0) begin failures++; $display("FAIL ign_accept busy=%b done=%b want=1,0", busy, frame_done); end
        for (int c = 1; c < 4; c++) drive_col4(c, 50, 1'b0);
        col_in_valid = 1'b0;
        for (int l = 0; l < 16; l++) begin
            checks++; if (row_out_r !== exp4(l, 1, 50, 0) || row_out_i !== exp4(l, 1, 50, 1)) begin
                failures++; $display("FAIL b2b_data beat=%0d got=%h want=%h", l, row_out_r, exp4(l, 1, 50, 0)); end
            @(negedge clk);
        end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b want=1", frame_done); end
    endtask

    task automatic test_async_reset;
        for (int c = 0; c < 4; c++) drive_col4(c, 0, c == 0);
        col_in_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (row_out_r !== exp4(7, 1, 0, 0)) begin failures++; $display("FAIL rst_pre_beat7 got=%h want=%h", row_out_r, exp4(7, 1, 0, 0)); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (row_out_r !== '0 || row_out_i !== '0 || row_out_f !== 3'b000) begin
            failures++; $display("FAIL rst_async_data r=%h i=%h f=%b want=0", row_out_r, row_out_i, row_out_f); end
        checks++; if (row_out_valid !== 1'b0 || col_in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++; $display("FAIL rst_async_ctrl valid=%b ready=%b busy=%b done=%b want=0,1,0,0", row_out_valid, col_in_ready, busy, frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 4; c++) drive_col4(c, 20, 1'b0);
        col_in_valid = 1'b0;
        for (int l = 0; l < 12; l++) begin
            checks++; if (row_out_r !== exp4(l, 0, 20, 0) || row_out_i !== exp4(l, 0, 20, 1) || row_out_f !== expf4(l)) begin
                failures++; $display("FAIL rst_refeed beat=%0d got=%h want=%h", l, row_out_r, exp4(l, 0, 20, 0)); end
            @(negedge clk);
        end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL rst_refeed_done got=%b want=1", frame_done); end
    endtask

    task automatic test_n8;
        cr8 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 8; j++) begin
                c8_r[j*16 +: 16] = 16'(10*j + c);
                c8_i[j*16 +: 16] = 16'(-(10*j + c));
            end
            c8_valid = 1'b1;
            aug8 = (c == 0);
            @(negedge clk);
        end
        c8_valid = 1'b0;
        for (int l = 0; l < 23; l++) begin
            checks++; if (o8_r !== exp8(l, 0) || o8_i !== exp8(l, 1)) begin failures++; $display("FAIL n8_data beat=%0d got=%h want=%h", l, o8_r, exp8(l, 0)); end
            checks++; if (o8_f !== expf8(l)) begin failures++; $display("FAIL n8_f beat=%0d got=%b want=%b", l, o8_f, expf8(l)); end
            if (l == 12) begin
                checks++; if (o8_f !== 7'b1000000) begin failures++; $display("FAIL n8_row6_flag got=%b want=1000000", o8_f); end
            end
            if (l == 22) begin
                checks++; if (o8_r[127:112] !== 16'd4096) begin failures++; $display("FAIL n8_row7_diag got=%0d want=4096", o8_r[127:112]); end
            end
            @(negedge clk);
        end
        checks++; if (done8 !== 1'b1 || o8_valid !== 1'b0) begin failures++; $display("FAIL n8_done done=%b valid=%b want=1,0", done8, o8_valid); end
    endtask

    initial begin
        test_reset();
        test_aug_frame();
        test_noaug();
        test_stall();
        test_feed_ignore();
        test_async_reset();
        test_n8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
